// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the rs232_tx share arbiter.
// master is the surrounding fabric, slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic              en0;
  logic [DATA_W-1:0] data0;
  logic              busy0;
  logic              req1;
  logic              en1;
  logic [DATA_W-1:0] data1;
  logic              busy1;
  logic [DATA_W-1:0] tx_data;
  logic              tx_enable;
  logic              tx_ready;
  logic [1:0]        grant;
  logic              line_busy;
  logic              collision;
  logic              timeout;

  modport master (
    output req0, en0, data0,
    output req1, en1, data1,
    output tx_ready,
    input  busy0, busy1,
    input  tx_data, tx_enable,
    input  grant, line_busy,
    input  collision, timeout
  );

  modport slave (
    input  req0, en0, data0,
    input  req1, en1, data1,
    input  tx_ready,
    output busy0, busy1,
    output tx_data, tx_enable,
    output grant, line_busy,
    output collision, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin share of one rs232_tx between two byte streams,
// with per-grant inactivity timeout and local line occupancy tracking.
module uart_tx_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 50000,
  parameter int TMO_W   = 16
) (
  input  logic clk,
  input  logic rst,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    RELEASE
  } state_t;

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [1:0]        grant_q, grant_n;
  logic              last_q, last_n;
  logic [TMO_W-1:0]  tmo_q, tmo_n;
  logic [DATA_W-1:0] data_q;
  logic              enable_q;
  logic              line_q;
  logic              col_q;
  logic              tmo_pulse_q;

  logic              held;
  logic              busy0, busy1;
  logic              acc0, acc1, acc;
  logic              drop;
  logic              idle_cnt;
  logic              expire;
  logic              owner_req;
  logic [DATA_W-1:0] data_sel;

  assign held  = (state == GRANTED);
  assign busy0 = ~(held & grant_q[0]) | line_q;
  assign busy1 = ~(held & grant_q[1]) | line_q;

  assign acc0 = bus.en0 & ~busy0;
  assign acc1 = bus.en1 & ~busy1;
  assign acc  = acc0 | acc1;
  assign drop = (bus.en0 & busy0) | (bus.en1 & busy1);

  assign data_sel  = acc1 ? bus.data1 : bus.data0;
  assign idle_cnt  = held & ~line_q & ~acc;
  assign expire    = idle_cnt & (tmo_q == TMO_MAX);
  assign owner_req = (grant_q[0] & bus.req0)
                   | (grant_q[1] & bus.req1);

  always_comb begin
    state_n = state;
    grant_n = grant_q;
    last_n  = last_q;
    tmo_n   = '0;
    unique case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_n = GRANTED;
          // last holds the previous owner: 1 means port 1
          if (bus.req0 & bus.req1)
            grant_n = last_q ? 2'b01 : 2'b10;
          else
            grant_n = bus.req0 ? 2'b01 : 2'b10;
        end
      end
      GRANTED: begin
        if (expire | ~owner_req)
          state_n = RELEASE;
        else if (idle_cnt)
          tmo_n = tmo_q + 1'b1;
      end
      RELEASE: begin
        if (~line_q) begin
          state_n = IDLE;
          grant_n = 2'b00;
          last_n  = grant_q[1];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      tmo_q       <= '0;
      data_q      <= '0;
      enable_q    <= 1'b0;
      line_q      <= 1'b0;
      col_q       <= 1'b0;
      tmo_pulse_q <= 1'b0;
    end else begin
      state       <= state_n;
      grant_q     <= grant_n;
      last_q      <= last_n;
      tmo_q       <= tmo_n;
      enable_q    <= acc;
      col_q       <= drop;
      tmo_pulse_q <= expire;
      if (acc)
        data_q <= data_sel;
      if (acc)
        line_q <= 1'b1;
      else if (bus.tx_ready)
        line_q <= 1'b0;
    end
  end

  assign bus.busy0     = busy0;
  assign bus.busy1     = busy1;
  assign bus.tx_data   = data_q;
  assign bus.tx_enable = enable_q;
  assign bus.grant     = grant_q;
  assign bus.line_busy = line_q;
  assign bus.collision = col_q;
  assign bus.timeout   = tmo_pulse_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: packet ownership model checked
// every cycle plus hand-computed literal expectations.
module tb_uart_tx_arbiter;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .DATA_W (DW),
    .TIMEOUT(TMO),
    .TMO_W  (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // owner: -1 none, else port number; rel marks a grant being given up
  int          m_own  = -1;
  bit          m_rel  = 1'b0;
  int          m_last = 1;
  int          m_idle = 0;
  bit          m_fly  = 1'b0;
  bit          m_fire = 1'b0;
  bit          m_col  = 1'b0;
  bit          m_tmo  = 1'b0;
  logic [DW-1:0] m_byte = '0;

  always @(posedge clk or negedge rst) begin : model
    bit [1:0] rq;
    bit [1:0] en;
    bit       held;
    bit       take;
    bit       drop;
    bit       expire;
    if (!rst) begin
      m_own  <= -1;
      m_rel  <= 1'b0;
      m_last <= 1;
      m_idle <= 0;
      m_fly  <= 1'b0;
      m_fire <= 1'b0;
      m_col  <= 1'b0;
      m_tmo  <= 1'b0;
      m_byte <= '0;
    end else begin
      rq   = {bus.req1, bus.req0};
      en   = {bus.en1, bus.en0};
      held = (m_own >= 0) && !m_rel;
      take = 1'b0;
      drop = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (en[p]) begin
          if (held && m_own == p && !m_fly)
            take = 1'b1;
          else
            drop = 1'b1;
        end
      end
      m_fire <= take;
      m_col  <= drop;
      m_tmo  <= 1'b0;
      if (take)
        m_byte <= (m_own == 0) ? bus.data0 : bus.data1;
      if (take)
        m_fly <= 1'b1;
      else if (bus.tx_ready)
        m_fly <= 1'b0;
      if (m_own < 0) begin
        m_idle <= 0;
        if (rq == 2'b11)
          m_own <= 1 - m_last;
        else if (rq == 2'b01)
          m_own <= 0;
        else if (rq == 2'b10)
          m_own <= 1;
      end else if (held) begin
        expire = !take && !m_fly && (m_idle == TMO - 1);
        if (take || m_fly || expire)
          m_idle <= 0;
        else
          m_idle <= m_idle + 1;
        if (expire) begin
          m_tmo <= 1'b1;
          m_rel <= 1'b1;
        end
        if (!rq[m_own])
          m_rel <= 1'b1;
      end else if (!m_fly) begin
        m_last <= m_own;
        m_own  <= -1;
        m_rel  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] eg;
    bit         eb0;
    bit         eb1;
    if (rst) begin
      eg  = (m_own < 0) ? 2'b00 : (m_own == 0 ? 2'b01 : 2'b10);
      eb0 = !(m_own == 0 && !m_rel) || m_fly;
      eb1 = !(m_own == 1 && !m_rel) || m_fly;
      chk("m_grant", bus.grant, eg);
      chk("m_busy0", bus.busy0, eb0);
      chk("m_busy1", bus.busy1, eb1);
      chk("m_tx_enable", bus.tx_enable, m_fire);
      chk("m_tx_data", bus.tx_data, m_byte);
      chk("m_line_busy", bus.line_busy, m_fly);
      chk("m_collision", bus.collision, m_col);
      chk("m_timeout", bus.timeout, m_tmo);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic strobe(input int p, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.en0   = 1'b1;
      bus.data0 = d;
    end else begin
      bus.en1   = 1'b1;
      bus.data1 = d;
    end
    cyc(1);
    bus.en0 = 1'b0;
    bus.en1 = 1'b0;
  endtask

  task automatic ready_pulse();
    bus.tx_ready = 1'b1;
    cyc(1);
    bus.tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.en0  = 1'b0;
    bus.en1  = 1'b0;
    bus.tx_ready = 1'b0;
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.en0  = 1'b0;
    bus.en1  = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    bus.tx_ready = 1'b0;
    cyc(2);
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_busy0", bus.busy0, 1'b1);
    chk("rst_busy1", bus.busy1, 1'b1);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_tx_enable", bus.tx_enable, 1'b0);
    chk("rst_line_busy", bus.line_busy, 1'b0);
    rst = 1'b1;
    cyc(1);

    // single port byte
    bus.req0 = 1'b1;
    cyc(1);
    chk("sp_grant", bus.grant, 2'b01);
    chk("sp_busy0", bus.busy0, 1'b0);
    chk("sp_busy1", bus.busy1, 1'b1);
    strobe(0, 8'hA5);
    chk("sp_tx_enable", bus.tx_enable, 1'b1);
    chk("sp_tx_data", bus.tx_data, 8'hA5);
    chk("sp_line_busy", bus.line_busy, 1'b1);
    chk("sp_busy0_fly", bus.busy0, 1'b1);
    cyc(2);
    chk("sp_busy0_wait", bus.busy0, 1'b1);
    ready_pulse();
    chk("sp_line_clr", bus.line_busy, 1'b0);
    chk("sp_busy0_free", bus.busy0, 1'b0);
    bus.req0 = 1'b0;
    cyc(1);
    chk("sp_rel_grant", bus.grant, 2'b01);
    cyc(1);
    chk("sp_idle_grant", bus.grant, 2'b00);

    // tie from reset, 3-byte packet, round robin
    do_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    cyc(1);
    chk("tie_first", bus.grant, 2'b01);
    for (int k = 0; k < 3; k++) begin
      strobe(0, 8'h10 + 8'(k));
      chk("pkt_byte", bus.tx_data, 8'h10 + 8'(k));
      cyc(1);
      ready_pulse();
    end
    bus.req0 = 1'b0;
    cyc(2);
    chk("rr_gap", bus.grant, 2'b00);
    cyc(1);
    chk("rr_port1", bus.grant, 2'b10);
    bus.req0 = 1'b1;
    bus.req1 = 1'b0;
    cyc(1);
    chk("rr_rel1", bus.grant, 2'b10);
    cyc(1);
    chk("rr_idle", bus.grant, 2'b00);
    bus.req1 = 1'b1;
    cyc(1);
    chk("rr_tie_port0", bus.grant, 2'b01);

    // collisions
    strobe(1, 8'hEE);
    chk("col_nonowner", bus.collision, 1'b1);
    chk("col_no_en", bus.tx_enable, 1'b0);
    strobe(0, 8'h3C);
    chk("col_ok_en", bus.tx_enable, 1'b1);
    chk("col_ok_data", bus.tx_data, 8'h3C);
    strobe(0, 8'hC3);
    chk("col_linebusy", bus.collision, 1'b1);
    chk("col_data_kept", bus.tx_data, 8'h3C);
    chk("col_no_en2", bus.tx_enable, 1'b0);
    ready_pulse();

    // timeout
    do_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    cyc(1);
    chk("tmo_grant", bus.grant, 2'b01);
    cyc(15);
    chk("tmo_early", bus.timeout, 1'b0);
    chk("tmo_hold", bus.grant, 2'b01);
    cyc(1);
    chk("tmo_pulse", bus.timeout, 1'b1);
    cyc(1);
    chk("tmo_drop", bus.grant, 2'b00);
    chk("tmo_once", bus.timeout, 1'b0);
    cyc(1);
    chk("tmo_other", bus.grant, 2'b10);

    // release while a byte is in flight
    strobe(1, 8'h5A);
    chk("rif_en", bus.tx_enable, 1'b1);
    bus.req1 = 1'b0;
    cyc(1);
    chk("rif_hold", bus.grant, 2'b10);
    chk("rif_busy1", bus.busy1, 1'b1);
    cyc(2);
    chk("rif_hold2", bus.grant, 2'b10);
    ready_pulse();
    chk("rif_lineclr", bus.line_busy, 1'b0);
    chk("rif_hold3", bus.grant, 2'b10);
    cyc(1);
    chk("rif_free", bus.grant, 2'b00);
    cyc(1);
    chk("rif_next", bus.grant, 2'b01);

    // async reset mid-byte
    strobe(0, 8'h77);
    chk("ar_en", bus.tx_enable, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_grant", bus.grant, 2'b00);
    chk("ar_line", bus.line_busy, 1'b0);
    chk("ar_busy0", bus.busy0, 1'b1);
    chk("ar_busy1", bus.busy1, 1'b1);
    chk("ar_en_clr", bus.tx_enable, 1'b0);
    cyc(1);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    rst = 1'b1;
    cyc(1);
    chk("ar_regrant", bus.grant, 2'b01);
    ready_pulse();
    chk("ar_stale_rdy", bus.line_busy, 1'b0);
    bus.req0 = 1'b0;
    cyc(4);
    chk("ar_final", bus.grant, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one rs232_tx byte transmitter between two byte-stream requesters: the cmi_coder telemetry stream (port 0) and a parameter-reply stream (port 1).
- Grants are held for a whole packet, with round-robin between packets and a per-grant inactivity timeout.
- Tracks transmitter occupancy itself and presents a per-requester busy, so callers use their existing tx_busy/tx_enable/tx_data handshake unchanged.
- Sits between the coders and rs232_tx in the drive top level.

Parameters:
- DATA_W, 8, byte width on all data ports.
- TIMEOUT, 50000, idle cycles (no byte accepted, line idle) before a held grant is revoked; 1 ms at 50 MHz.
- TMO_W, 16, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous reset, active-low.
- req0  in  1  port 0 packet request; level, held high for the whole packet.
- en0  in  1  port 0 byte strobe, 1 cycle.
- data0  in  DATA_W  port 0 byte; valid with en0.
- busy0  out  1  port 0 must not strobe while high.
- req1 / en1 / data1 / busy1  same as port 0, for port 1.
- tx_data  out  DATA_W  byte to rs232_tx iCode.
- tx_enable  out  1  1-cycle strobe to rs232_tx iCodeEn.
- tx_ready  in  1  1-cycle done pulse from rs232_tx oTxDReady.
- grant  out  2  one-hot current owner; 00 when none.
- line_busy  out  1  byte in flight (issued, tx_ready not yet seen).
- collision  out  1  1-cycle pulse when a strobe is dropped.
- timeout  out  1  1-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rst low, async): state IDLE; grant=00; tx_data=0; tx_enable=0; line_busy=0; collision=0; timeout=0; busy0=busy1=1; last=1, so port 0 wins the first tie; tmo_cnt=0.
- States: IDLE, GRANTED, RELEASE.
- IDLE:
  - Only req0 high -> grant=01. Only req1 high -> grant=10.
  - Both high -> grant the port not equal to last.
  - Grant registers on the cycle after req is sampled; state becomes GRANTED.
  - Neither high -> remain in IDLE.
- busy_i = ~(state==GRANTED & grant[i]) | line_busy. This is combinational from registers.
- GRANTED, byte accept: en_g with busy_g=0 latches data_g into tx_data. tx_enable pulses the following cycle (1-cycle latency). line_busy is set in the same cycle as tx_enable.
- line_busy clears on tx_ready. If tx_enable and tx_ready occur in the same cycle, set wins.
- Dropped strobe: any en_i while busy_i=1 (not owner, or line busy) is dropped. collision pulses the next cycle; tx_data is unchanged.
- Timeout counter: tmo_cnt counts while in GRANTED with line_busy=0 and no accepted strobe. It clears on any accept, on any exit from GRANTED, and while line_busy=1.
- Timeout expiry: when tmo_cnt reaches TIMEOUT-1, the timeout pulse fires and the state goes to RELEASE.
- Owner release: owner req deasserted in GRANTED -> RELEASE. A strobe in that same cycle is still accepted.
- RELEASE:
  - grant stays asserted; busy of the owner is forced to 1.
  - Wait until line_busy=0, then set last=owner and grant=00, and go to IDLE.
  - The next grant follows no earlier than one cycle later.
  - A requester whose grant timed out and still holds req competes again in IDLE; round-robin favours the other port if both request.
- Non-owner req toggling has no effect during GRANTED or RELEASE.
- Async reset mid-byte: all state clears immediately. rs232_tx is reset by the same rst, so no stale tx_ready is expected. Any tx_ready seen while line_busy=0 is ignored.
- Widths: no arithmetic on data. tmo_cnt saturates at TIMEOUT-1 and never wraps.

Test Plan:
- Single port: req0=1, en0 with data0=0xA5 at cycle 5 -> grant=01 by cycle 2; tx_enable at cycle 6 with tx_data=0xA5; busy0=1 until tx_ready; then req0=0 -> grant=00 after line_busy clears.
- Tie and round-robin: req0 and req1 high together from reset -> port 0 granted. After its 3-byte packet and release -> port 1 granted. Next tie -> port 0 granted.
- Collision: en1=1 while grant=01 -> collision pulse, no tx_enable. en0 while line_busy=1 -> collision pulse, tx_data unchanged.
- Timeout, with TIMEOUT=16 for sim: req0 held, no en0 -> timeout pulse 16 cycles after grant; grant=00; with req1 high, grant=10 next.
- Release during flight: req0 drops the cycle after tx_enable -> grant stays 01 in RELEASE until tx_ready, then grant=00; pending req1 is granted one cycle later.
- Async reset: pull rst low between tx_enable and tx_ready -> grant=00, line_busy=0, busy0=busy1=1 immediately without a clock edge; after release, normal arbitration with port 0 preferred.
